// File: rtl/thermal_shutdown_ctrl.sv
// thermal_shutdown_ctrl
// Multi-channel overheat supervisor. Each of NCH unsigned TW-bit readings is
// compared against TRIP. Sustained heat (DEBOUNCE consecutive cycles with any
// enabled channel at or above TRIP) latches a registered shutdown. Shutdown is
// released only after COOL_CYCLES consecutive all-cool cycles in COOLDOWN,
// followed by a software clear. Cool means below TRIP-HYST, so the band in
// between counts as neither hot nor cool.
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   temp              NCH packed readings, channel i at [i*TW +: TW]
//   ch_en             per-channel enable; disabled channels are never hot, always cool
//   clear             level request to leave shutdown, honoured only in COOLDOWN
//   shut_off_computer registered, high in SHUTDOWN and COOLDOWN
//   warn              registered, high in PENDING
//   trip_ch           sticky record of channels seen hot while shut down
//   state             encoded FSM state (0 NORMAL, 1 PENDING, 2 SHUTDOWN, 3 COOLDOWN)
module thermal_shutdown_ctrl #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned TW          = 8,
  parameter int unsigned TRIP        = 100,
  parameter int unsigned HYST        = 10,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned COOL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*TW-1:0] temp,
  input  logic [NCH-1:0]    ch_en,
  input  logic              clear,
  output logic              shut_off_computer,
  output logic              warn,
  output logic [NCH-1:0]    trip_ch,
  output logic [1:0]        state
);

  localparam int unsigned CNT_MAX = (DEBOUNCE > COOL_CYCLES) ? DEBOUNCE : COOL_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  localparam logic [TW-1:0] TRIP_T   = TW'(TRIP);
  localparam logic [TW-1:0] COOL_T   = TW'(TRIP - HYST);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] COOL_LIM = CW'(COOL_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    PENDING  = 2'd1,
    SHUTDOWN = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shut_q, shut_d;
  logic             warn_q, warn_d;
  logic [NCH-1:0]   trip_q, trip_d;

  logic [NCH-1:0]   hot, cool;
  logic             any_hot, all_cool;

  // Per-channel classification. Readings in [TRIP-HYST, TRIP-1] are
  // deliberately neither hot nor cool.
  always_comb begin
    hot  = '0;
    cool = '1;
    for (int unsigned i = 0; i < NCH; i++) begin
      hot[i]  = ch_en[i] & (temp[i*TW +: TW] >= TRIP_T);
      cool[i] = ~ch_en[i] | (temp[i*TW +: TW] < COOL_T);
    end
  end

  assign any_hot  = |hot;
  assign all_cool = &cool;

  // Next-state, counter and sticky trip record.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trip_d  = trip_q;

    case (state_q)
      NORMAL: begin
        if (any_hot) begin
          if (DEBOUNCE == 1) begin
            state_d = SHUTDOWN;
          end else begin
            state_d = PENDING;
            cnt_d   = CNT_ONE;
          end
        end
      end

      PENDING: begin
        // Any non-hot cycle breaks the run completely.
        if (!any_hot) begin
          state_d = NORMAL;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SHUTDOWN;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SHUTDOWN: begin
        if (all_cool) begin
          state_d = COOLDOWN;
          cnt_d   = '0;
        end
      end

      COOLDOWN: begin
        // Re-heat (including the hysteresis band) beats a simultaneous clear.
        if (!all_cool) begin
          state_d = SHUTDOWN;
          cnt_d   = '0;
        end else if ((cnt_q == COOL_LIM) && clear) begin
          state_d = NORMAL;
          cnt_d   = '0;
          trip_d  = '0;
        end else if (cnt_q < COOL_LIM) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = NORMAL;
        cnt_d   = '0;
      end
    endcase

    // Accumulate on every cycle that ends in SHUTDOWN, which covers the entry
    // edge from any state as well as cycles spent there.
    if (state_d == SHUTDOWN) begin
      trip_d = trip_d | hot;
    end

    shut_d = (state_d == SHUTDOWN) || (state_d == COOLDOWN);
    warn_d = (state_d == PENDING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      shut_q  <= 1'b0;
      warn_q  <= 1'b0;
      trip_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shut_q  <= shut_d;
      warn_q  <= warn_d;
      trip_q  <= trip_d;
    end
  end

  assign shut_off_computer = shut_q;
  assign warn              = warn_q;
  assign trip_ch           = trip_q;
  assign state             = state_q;

endmodule

// File: doc/thermal_shutdown_ctrl.md
Name: thermal_shutdown_ctrl

Overview:
- Parametrised, multi-channel overheat supervisor; the registered successor to the team's single-bit overheat shutdown logic.
- Compares NCH unsigned temperature readings against a trip threshold.
- Debounces trip events and drives a sticky registered shut_off_computer.
- Releases shutdown only after a hysteresis-qualified cooldown period plus an explicit software clear.

Parameters:
- NCH, 4: number of temperature channels (1..16).
- TW, 8: width of each temperature reading, in bits.
- TRIP, 100: trip threshold, unsigned TW-bit. Constraint: TRIP >= HYST.
- HYST, 10: hysteresis. A channel counts as cool when temp < TRIP-HYST.
- DEBOUNCE, 4: consecutive hot cycles required to trip (>= 1).
- COOL_CYCLES, 16: consecutive all-cool cycles required before clear is accepted (>= 1).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- temp, input, NCH*TW: channel i occupies bits [i*TW +: TW]; unsigned.
- ch_en, input, NCH: per-channel enable. Disabled channels are never hot and always cool.
- clear, input, 1: level request to leave shutdown. Sampled only in COOLDOWN.
- shut_off_computer, output, 1: registered; high in SHUTDOWN and COOLDOWN.
- warn, output, 1: registered; high while in PENDING.
- trip_ch, output, NCH: sticky per-channel record of channels hot during SHUTDOWN.
- state, output, 2: encoded FSM state.

Behaviour:
- Combinational terms:
  - hot[i] = ch_en[i] & (temp_i >= TRIP)
  - any_hot = |hot
  - cool[i] = ~ch_en[i] | (temp_i < TRIP-HYST)
  - all_cool = &cool
- Reset (rst_n low, asynchronous): state=NORMAL(0), cnt=0, shut_off_computer=0, warn=0, trip_ch=0. Reset asserted mid-shutdown also forces these values immediately, with no cooldown.
- cnt: internal counter, width clog2(max(DEBOUNCE,COOL_CYCLES))+1; saturates and never wraps.
- NORMAL (0):
  - any_hot & DEBOUNCE==1 -> SHUTDOWN.
  - any_hot otherwise -> PENDING, cnt=1.
  - else stay.
- PENDING (1), warn=1:
  - !any_hot -> NORMAL, cnt=0. The debounce run is broken; no partial credit is kept.
  - any_hot & cnt==DEBOUNCE-1 -> SHUTDOWN.
  - else cnt++.
  - Net effect: shut_off_computer rises on the edge sampling the DEBOUNCE-th consecutive any_hot cycle. Different channels may supply consecutive hot cycles.
- SHUTDOWN (2), shut_off_computer=1:
  - trip_ch |= hot on every cycle, including the entry edge.
  - all_cool -> COOLDOWN, cnt=0; else stay.
- COOLDOWN (3), shut_off_computer=1:
  - !all_cool -> SHUTDOWN, cnt=0 (re-heat restarts the cooldown).
  - Otherwise cnt increments, saturating at COOL_CYCLES.
  - cnt==COOL_CYCLES & clear & all_cool -> NORMAL: shut_off_computer=0, trip_ch=0, cnt=0.
  - clear before cnt reaches COOL_CYCLES is ignored and not remembered.
- clear in NORMAL, PENDING or SHUTDOWN: no effect.
- Simultaneous clear and re-heat in COOLDOWN: re-heat wins (-> SHUTDOWN).
- Readings between TRIP-HYST and TRIP-1 are neither hot nor cool:
  - NORMAL/PENDING treat them as not hot.
  - SHUTDOWN stays put.
  - COOLDOWN returns to SHUTDOWN.
- ch_en changes take effect in the same cycle. Disabling the only hot channel in PENDING returns to NORMAL.
- ch_en == 0: NORMAL is permanent and any shutdown can complete cooldown.
- All outputs are registered: at most one edge of latency from the qualifying input to the output change.

Test Plan:
- Defaults; ch0 temp=100 for 4 cycles -> warn=1 for edges 1-3, shut_off_computer=1 and trip_ch=0001 at edge 4, state=2.
- ch1 temp=120 for 3 cycles, then 50 for 1 cycle, then 120 for 4 cycles -> no shutdown after the first run (returns to NORMAL); shutdown on the 4th cycle of the second run.
- In SHUTDOWN, drop all temps to 89 -> COOLDOWN; hold 16 cycles with clear=1 from cycle 5 -> clear ignored until cnt=16, then NORMAL, shut_off_computer=0, trip_ch=0.
- In COOLDOWN at cnt=10, raise ch2 to 95 (hysteresis band) -> back to SHUTDOWN, cnt=0. Cooling then restarts the full 16-cycle wait.
- ch3 temp=200 with ch_en[3]=0 -> no warn, no shutdown. Set ch_en[3]=1 -> shutdown after 4 cycles, trip_ch=1000.
- Assert rst_n=0 asynchronously (between clock edges) during COOLDOWN -> outputs zero immediately. With temps normal after release, stays in NORMAL.
